// File: rtl/flush_pump_pwm_ramp_ctrl.sv
// Flush pump PWM generator with soft start/stop.
// The applied duty slews toward the CPU setpoint once per PWM period. When the pump is
// disabled, the duty ramps down to zero and the block then parks in IDLE.
module flush_pump_pwm_ramp_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [31:0]      duty_set,
    input  logic [CNT_W-1:0] ramp_step,
    output logic             pwm_out,
    output logic [CNT_W:0]   duty_act,
    output logic             at_set,
    output logic             period_end,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W:0]   duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             pend_q, pend_d;

    logic             boundary;
    logic [CNT_W:0]   per_lim;   // full-on duty for the running period
    logic [CNT_W:0]   new_lim;   // full-on duty for the period loaded at this boundary
    logic [CNT_W:0]   tgt_run;   // setpoint saturated to the running period
    logic [CNT_W:0]   step_tgt;  // target actually used by the boundary step
    logic [CNT_W:0]   duty_bnd;  // duty that takes effect if this cycle is a boundary

    // Saturate the 32-bit setpoint into the representable duty range [0, lim].
    function automatic logic [CNT_W:0] sat_target(input logic [31:0] ds,
                                                  input logic [CNT_W:0] lim);
        logic [CNT_W:0] lo;
        lo = {1'b0, ds[CNT_W-1:0]};
        if ((ds[31:CNT_W] != '0) || (lo > lim)) begin
            return lim;
        end
        return lo;
    endfunction

    // Move cur toward tgt by at most step; a step of zero jumps straight to tgt.
    function automatic logic [CNT_W:0] slew(input logic [CNT_W:0]   cur,
                                            input logic [CNT_W:0]   tgt,
                                            input logic [CNT_W-1:0] step);
        logic [CNT_W:0] diff;
        logic [CNT_W:0] stp;
        stp  = {1'b0, step};
        diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if ((step == '0) || (diff <= stp)) begin
            return tgt;
        end else if (tgt > cur) begin
            return cur + stp;
        end
        return cur - stp;
    endfunction

    assign per_lim  = {1'b0, per_q}  + {{CNT_W{1'b0}}, 1'b1};
    assign new_lim  = {1'b0, period} + {{CNT_W{1'b0}}, 1'b1};
    assign tgt_run  = sat_target(duty_set, per_lim);
    // Dropping enable on a boundary cycle already steps toward zero.
    assign step_tgt = enable ? tgt_run : '0;
    assign boundary = (state_q != IDLE) && (cnt_q == per_q);

    // Boundary duty: slew step, then clamp in case the new period is shorter.
    always_comb begin
        duty_bnd = slew(duty_q, step_tgt, ramp_step);
        if (duty_bnd > new_lim) begin
            duty_bnd = new_lim;
        end
    end

    // Next-state, counter, period latch and duty update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        duty_d  = duty_q;
        pwm_d   = (state_q != IDLE) && ({1'b0, cnt_q} < duty_q);
        pend_d  = boundary;

        if (boundary) begin
            per_d  = period;
            duty_d = duty_bnd;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RAMP;
                    per_d   = period;
                end
            end
            RAMP: begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                if (!enable) begin
                    state_d = STOP;
                end else if (boundary && (duty_bnd == tgt_run)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                if (!enable) begin
                    state_d = STOP;
                end else if (tgt_run != duty_q) begin
                    state_d = RAMP;
                end
            end
            STOP: begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                if (enable) begin
                    state_d = RAMP;
                end else if (boundary && (duty_bnd == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            pend_q  <= pend_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign duty_act   = duty_q;
    assign period_end = pend_q;
    assign state_o    = state_q;
    assign at_set     = (state_q == HOLD) && (duty_q == tgt_run);

endmodule
